coin_tally: RTL

- Consumes the four debounced beam-broken lines (penny, nickel, dime, quarter) from the beam-break stage and turns each rising edge into one coin event.
- Queues coin events in a small FIFO for the processor.
- Keeps saturating per-denomination counts and a running cents total.
- Drives the acknowledgeBeam bus back to the beam-break stage.

---
 rtl/coin_tally.sv | 122 ++++++++++++
 1 files changed

// File: rtl/coin_tally.sv
// Coin tally: rising-edge detection on the four beam lines, a small coin-event FIFO,
// and saturating per-denomination counts plus a running cents total.
module coin_tally #(
  parameter int FIFO_DEPTH = 8,
  parameter int TOTAL_W    = 16,
  parameter int COUNT_W    = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          beamBroken1,
  input  logic                          beamBroken2,
  input  logic                          beamBroken3,
  input  logic                          beamBroken4,
  input  logic                          pop,
  input  logic                          clearTotals,
  output logic                          coinValid,
  output logic [1:0]                    coinType,
  output logic [$clog2(FIFO_DEPTH):0]   fifoCount,
  output logic [TOTAL_W-1:0]            totalCents,
  output logic [COUNT_W-1:0]            pennyCount,
  output logic [COUNT_W-1:0]            nickelCount,
  output logic [COUNT_W-1:0]            dimeCount,
  output logic [COUNT_W-1:0]            quarterCount,
  output logic [31:0]                   acknowledgeBeam,
  output logic                          overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [3:0]         beam, prev, rise, drop, pending, pending_next, grant;
  logic [1:0]         grant_idx;
  logic               push, do_pop, full;
  logic [1:0]         mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [AW:0]        count;
  logic [COUNT_W-1:0] coin_cnt  [4];
  logic [COUNT_W-1:0] cnt_base  [4];
  logic [COUNT_W-1:0] cnt_next  [4];
  logic [TOTAL_W-1:0] total, total_base, total_next;
  logic [TOTAL_W:0]   total_sum;
  logic [4:0]         coin_val;
  logic               ack, ovf;

  assign beam   = {beamBroken4, beamBroken3, beamBroken2, beamBroken1};
  assign rise   = beam & ~prev;
  // A rise on an already-pending denomination is lost; that is what overflow flags.
  assign drop   = rise & pending;
  assign full   = (count == (AW+1)'(FIFO_DEPTH));
  assign push   = (|pending) & ~full;
  assign do_pop = pop & (count != '0);

  always_comb begin
    grant_idx = 2'd3;
    if (pending[0])      grant_idx = 2'd0;
    else if (pending[1]) grant_idx = 2'd1;
    else if (pending[2]) grant_idx = 2'd2;

    grant = '0;
    if (push) grant[grant_idx] = 1'b1;
    pending_next = (pending & ~grant) | (rise & ~pending);

    coin_val = 5'd1;
    case (grant_idx)
      2'd0:    coin_val = 5'd1;
      2'd1:    coin_val = 5'd5;
      2'd2:    coin_val = 5'd10;
      default: coin_val = 5'd25;
    endcase

    // clearTotals coinciding with a push yields clear-then-add.
    total_base = clearTotals ? '0 : total;
    total_sum  = {1'b0, total_base} + (TOTAL_W+1)'(coin_val);
    total_next = total_base;
    if (push) total_next = total_sum[TOTAL_W] ? '1 : total_sum[TOTAL_W-1:0];

    for (int i = 0; i < 4; i++) begin
      cnt_base[i] = clearTotals ? '0 : coin_cnt[i];
      cnt_next[i] = cnt_base[i];
      if (grant[i] && (cnt_base[i] != '1)) cnt_next[i] = cnt_base[i] + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      prev    <= '1;
      pending <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      total   <= '0;
      ovf     <= 1'b0;
      ack     <= 1'b0;
      for (int i = 0; i < 4; i++) coin_cnt[i] <= '0;
    end else begin
      prev    <= beam;
      pending <= pending_next;
      ack     <= push;
      total   <= total_next;
      ovf     <= (ovf & ~clearTotals) | (|drop);
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !do_pop)      count <= count + 1'b1;
      else if (!push && do_pop) count <= count - 1'b1;
      for (int i = 0; i < 4; i++) coin_cnt[i] <= cnt_next[i];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && push) mem[wr_ptr] <= grant_idx;
  end

  assign coinValid       = (count != '0);
  assign coinType        = mem[rd_ptr];
  assign fifoCount       = count;
  assign totalCents      = total;
  assign pennyCount      = coin_cnt[0];
  assign nickelCount     = coin_cnt[1];
  assign dimeCount       = coin_cnt[2];
  assign quarterCount    = coin_cnt[3];
  assign acknowledgeBeam = {31'b0, ack};
  assign overflow        = ovf;

endmodule
